// File: rtl/patbuf_pkg.sv
// Shared types and default sizing for the pattern-buffer array.
package patbuf_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  localparam int NUM_BANKS_DEF = 8;
  localparam int DEPTH_DEF     = 22;
  localparam int WIDTH_DEF     = 8;

endpackage

// File: rtl/patbuf_bank.sv
// One pattern bank: DEPTH x WIDTH flops usable as a serial chain or a word array.
module patbuf_bank
  import patbuf_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     shift_en_i,
  input  logic                     sin_i,
  input  logic                     wr_en_i,
  input  logic [$clog2(DEPTH)-1:0] wr_addr_i,
  input  logic [WIDTH-1:0]         wr_data_i,
  input  logic [$clog2(DEPTH)-1:0] rd_addr_i,
  output logic [WIDTH-1:0]         rd_data_o,
  output logic                     last_bit_o
);

  localparam int N = DEPTH * WIDTH;

  // Bit k of the chain is entry k/WIDTH, bit k%WIDTH; bit 0 sits next to sin.
  logic [N-1:0] chain_q, chain_d;

  always_comb begin
    chain_d = chain_q;
    if (shift_en_i) begin
      chain_d = {chain_q[N-2:0], sin_i};
    end else if (wr_en_i) begin
      chain_d[int'(wr_addr_i)*WIDTH +: WIDTH] = wr_data_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chain_q <= '0;
    end else begin
      chain_q <= chain_d;
    end
  end

  assign rd_data_o  = (int'(rd_addr_i) < DEPTH) ? chain_q[int'(rd_addr_i)*WIDTH +: WIDTH] : '0;
  assign last_bit_o = chain_q[N-1];

endmodule

// File: rtl/patbuf_array.sv
// Array of serially loadable pattern banks with a word write port and a registered read port.
// Optional macro PATBUF_RDPIPE2_EN adds a second read register stage (latency 2).
module patbuf_array
  import patbuf_pkg::*;
#(
  parameter int NUM_BANKS = NUM_BANKS_DEF,
  parameter int DEPTH     = DEPTH_DEF,
  parameter int WIDTH     = WIDTH_DEF
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         ssel,
  input  logic [$clog2(NUM_BANKS)-1:0] saddr,
  input  logic                         sin,
  output logic                         sout,
  output logic                         load_done,
  input  logic                         wr_en,
  input  logic [$clog2(NUM_BANKS)-1:0] wr_bank,
  input  logic [$clog2(DEPTH)-1:0]     wr_addr,
  input  logic [WIDTH-1:0]             wr_data,
  output logic                         wr_err,
  input  logic                         rd_en,
  input  logic [$clog2(NUM_BANKS)-1:0] rd_bank,
  input  logic [$clog2(DEPTH)-1:0]     rd_addr,
  output logic [WIDTH-1:0]             rd_data,
  output logic                         rd_valid,
  output logic                         rd_err,
  output state_e                       dbg_state_o
);

  localparam int BW = $clog2(NUM_BANKS);
  localparam int N  = DEPTH * WIDTH;
  localparam int CW = $clog2(N);
  localparam logic [CW-1:0] LAST_BIT = CW'(N - 1);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [BW-1:0] lat_q, lat_d;
  logic          shift_go;
  logic [BW-1:0] ser_bank;

  // Handshake: ssel is a level enable sampled every rising edge; a shift occurs on
  // every edge where ssel=1 in IDLE or SHIFT, and dropping it aborts the load.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    lat_d    = lat_q;
    shift_go = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (ssel) begin
          shift_go = 1'b1;
          lat_d    = saddr;
          cnt_d    = CW'(1);
          state_d  = SHIFT;
        end
      end
      SHIFT: begin
        if (!ssel) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          shift_go = 1'b1;
          if (cnt_q == LAST_BIT) begin
            cnt_d   = '0;
            state_d = DONE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      lat_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      lat_q   <= lat_d;
    end
  end

  // The IDLE cycle that starts a load already shifts saddr's bank, so it also owns the bank.
  assign ser_bank = (state_q == IDLE) ? saddr : lat_q;

  logic ser_bank_ok, wr_oor, wr_conflict, wr_ok, rd_oor;
  assign ser_bank_ok = int'(ser_bank) < NUM_BANKS;
  assign wr_oor      = (int'(wr_bank) >= NUM_BANKS) || (int'(wr_addr) >= DEPTH);
  assign wr_conflict = ((state_q != IDLE) || ssel) && (wr_bank == ser_bank);
  assign wr_ok       = wr_en && !wr_oor && !wr_conflict;
  assign rd_oor      = (int'(rd_bank) >= NUM_BANKS) || (int'(rd_addr) >= DEPTH);

  logic [WIDTH-1:0]     bank_rd [NUM_BANKS];
  logic [NUM_BANKS-1:0] bank_last;

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    patbuf_bank #(
      .DEPTH(DEPTH),
      .WIDTH(WIDTH)
    ) u_bank (
      .clk       (clk),
      .rst_n     (rst_n),
      .shift_en_i(shift_go && (ser_bank == BW'(b))),
      .sin_i     (sin),
      .wr_en_i   (wr_ok && (wr_bank == BW'(b))),
      .wr_addr_i (wr_addr),
      .wr_data_i (wr_data),
      .rd_addr_i (rd_addr),
      .rd_data_o (bank_rd[b]),
      .last_bit_o(bank_last[b])
    );
  end

  assign sout        = ser_bank_ok ? bank_last[ser_bank] : 1'b0;
  assign load_done   = (state_q == DONE);
  assign dbg_state_o = state_q;

  logic [WIDTH-1:0] rd_mux;
  assign rd_mux = rd_oor ? '0 : bank_rd[rd_bank];

  logic [WIDTH-1:0] rd_data1_q;
  logic             rd_valid1_q, rd_err1_q, wr_err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data1_q  <= '0;
      rd_valid1_q <= 1'b0;
      rd_err1_q   <= 1'b0;
      wr_err_q    <= 1'b0;
    end else begin
      rd_valid1_q <= rd_en;
      rd_err1_q   <= rd_en && rd_oor;
      if (rd_en) rd_data1_q <= rd_mux;
      wr_err_q    <= wr_en && !wr_ok;
    end
  end

  assign wr_err = wr_err_q;

`ifdef PATBUF_RDPIPE2_EN
  logic [WIDTH-1:0] rd_data2_q;
  logic             rd_valid2_q, rd_err2_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data2_q  <= '0;
      rd_valid2_q <= 1'b0;
      rd_err2_q   <= 1'b0;
    end else begin
      rd_valid2_q <= rd_valid1_q;
      rd_err2_q   <= rd_err1_q;
      if (rd_valid1_q) rd_data2_q <= rd_data1_q;
    end
  end

  assign rd_data  = rd_data2_q;
  assign rd_valid = rd_valid2_q;
  assign rd_err   = rd_err2_q;
`else
  assign rd_data  = rd_data1_q;
  assign rd_valid = rd_valid1_q;
  assign rd_err   = rd_err1_q;
`endif

endmodule

// File: tb/tb_patbuf_array.sv
// Directed bench for patbuf_array: table of word read/write vectors plus serial-load sequences.
module tb_patbuf_array;
  import patbuf_pkg::*;

`ifdef PATBUF_RDPIPE2_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ssel, sin, sout, load_done;
  logic [2:0] saddr;
  logic       wr_en, wr_err;
  logic [2:0] wr_bank;
  logic [4:0] wr_addr;
  logic [7:0] wr_data;
  logic       rd_en, rd_valid, rd_err;
  logic [2:0] rd_bank;
  logic [4:0] rd_addr;
  logic [7:0] rd_data;
  state_e     dbg_state;

  int n_checks = 0;
  int n_pass   = 0;

  patbuf_array dut (
    .clk(clk), .rst_n(rst_n), .ssel(ssel), .saddr(saddr), .sin(sin), .sout(sout),
    .load_done(load_done), .wr_en(wr_en), .wr_bank(wr_bank), .wr_addr(wr_addr),
    .wr_data(wr_data), .wr_err(wr_err), .rd_en(rd_en), .rd_bank(rd_bank),
    .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid), .rd_err(rd_err),
    .dbg_state_o(dbg_state)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  typedef struct {
    logic       wr_en;
    logic [2:0] wr_bank;
    logic [4:0] wr_addr;
    logic [7:0] wr_data;
    logic       rd_en;
    logic [2:0] rd_bank;
    logic [4:0] rd_addr;
    logic       exp_wr_err;
    logic       exp_valid;
    logic       exp_err;
    logic [7:0] exp_data;
  } vec_t;

  vec_t vecs[15];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_vec(input vec_t v, input int idx);
    wr_en = v.wr_en; wr_bank = v.wr_bank; wr_addr = v.wr_addr; wr_data = v.wr_data;
    rd_en = v.rd_en; rd_bank = v.rd_bank; rd_addr = v.rd_addr;
    cyc();
    check($sformatf("vec%0d_wr_err", idx), wr_err, v.exp_wr_err);
    wr_en = 1'b0; rd_en = 1'b0;
    repeat (LAT - 1) cyc();
    check($sformatf("vec%0d_rd_valid", idx), rd_valid, v.exp_valid);
    check($sformatf("vec%0d_rd_err", idx), rd_err, v.exp_err);
    check($sformatf("vec%0d_rd_data", idx), rd_data, v.exp_data);
  endtask

  task automatic do_read(input logic [2:0] b, input logic [4:0] a, input logic [7:0] exp_d,
                         input logic exp_e, input string name);
    rd_en = 1'b1; rd_bank = b; rd_addr = a;
    cyc();
    rd_en = 1'b0;
    repeat (LAT - 1) cyc();
    check({name, "_valid"}, rd_valid, 1'b1);
    check({name, "_data"}, rd_data, exp_d);
    check({name, "_err"}, rd_err, exp_e);
  endtask

  task automatic do_write(input logic [2:0] b, input logic [4:0] a, input logic [7:0] d,
                          input logic exp_e, input string name);
    wr_en = 1'b1; wr_bank = b; wr_addr = a; wr_data = d;
    cyc();
    wr_en = 1'b0;
    check({name, "_wr_err"}, wr_err, exp_e);
  endtask

  // pat 0: 1,0,1,0...  pat 1: all ones  pat 2: ones only in the final 8 bits
  task automatic serial(input logic [2:0] b, input int n, input int pat,
                        output int done_at, output int pulses);
    done_at = -1; pulses = 0;
    ssel = 1'b1; saddr = b;
    for (int i = 0; i < n; i++) begin
      case (pat)
        0:       sin = (i % 2 == 0);
        1:       sin = 1'b1;
        default: sin = (i >= n - 8);
      endcase
      cyc();
      if (load_done) begin
        pulses++;
        if (done_at < 0) done_at = i;
      end
    end
    ssel = 1'b0; sin = 1'b0;
  endtask

  int done_at, pulses, extra;

  initial begin
    vecs[0]  = '{1'b0, 3'd0, 5'd0,  8'h00, 1'b1, 3'd3, 5'd0,  1'b0, 1'b1, 1'b0, 8'hAA};
    vecs[1]  = '{1'b0, 3'd0, 5'd0,  8'h00, 1'b1, 3'd3, 5'd21, 1'b0, 1'b1, 1'b0, 8'hAA};
    vecs[2]  = '{1'b0, 3'd0, 5'd0,  8'h00, 1'b1, 3'd0, 5'd0,  1'b0, 1'b1, 1'b0, 8'h00};
    vecs[3]  = '{1'b0, 3'd0, 5'd0,  8'h00, 1'b1, 3'd7, 5'd10, 1'b0, 1'b1, 1'b0, 8'h00};
    vecs[4]  = '{1'b1, 3'd5, 5'd21, 8'hC3, 1'b0, 3'd0, 5'd0,  1'b0, 1'b0, 1'b0, 8'h00};
    vecs[5]  = '{1'b0, 3'd0, 5'd0,  8'h00, 1'b1, 3'd5, 5'd21, 1'b0, 1'b1, 1'b0, 8'hC3};
    vecs[6]  = '{1'b1, 3'd2, 5'd22, 8'h5A, 1'b0, 3'd0, 5'd0,  1'b1, 1'b0, 1'b0, 8'hC3};
    vecs[7]  = '{1'b0, 3'd0, 5'd0,  8'h00, 1'b1, 3'd2, 5'd22, 1'b0, 1'b1, 1'b1, 8'h00};
    vecs[8]  = '{1'b0, 3'd0, 5'd0,  8'h00, 1'b1, 3'd5, 5'd21, 1'b0, 1'b1, 1'b0, 8'hC3};
    vecs[9]  = '{1'b0, 3'd0, 5'd0,  8'h00, 1'b1, 3'd2, 5'd30, 1'b0, 1'b1, 1'b1, 8'h00};
    vecs[10] = '{1'b1, 3'd2, 5'd21, 8'h11, 1'b0, 3'd0, 5'd0,  1'b0, 1'b0, 1'b0, 8'h00};
    vecs[11] = '{1'b0, 3'd0, 5'd0,  8'h00, 1'b1, 3'd2, 5'd21, 1'b0, 1'b1, 1'b0, 8'h11};
    vecs[12] = '{1'b1, 3'd5, 5'd21, 8'h7E, 1'b1, 3'd5, 5'd21, 1'b0, 1'b1, 1'b0, 8'hC3};
    vecs[13] = '{1'b0, 3'd0, 5'd0,  8'h00, 1'b1, 3'd5, 5'd21, 1'b0, 1'b1, 1'b0, 8'h7E};
    vecs[14] = '{1'b0, 3'd0, 5'd0,  8'h00, 1'b0, 3'd0, 5'd0,  1'b0, 1'b0, 1'b0, 8'h7E};

    rst_n = 1'b0; ssel = 1'b0; saddr = '0; sin = 1'b0;
    wr_en = 1'b0; wr_bank = '0; wr_addr = '0; wr_data = '0;
    rd_en = 1'b0; rd_bank = '0; rd_addr = '0;
    repeat (2) cyc();
    check("reset_state", 32'(dbg_state), 32'(IDLE));
    check("reset_sout", sout, 1'b0);
    check("reset_load_done", load_done, 1'b0);
    check("reset_wr_err", wr_err, 1'b0);
    check("reset_rd_valid", rd_valid, 1'b0);
    check("reset_rd_data", rd_data, 8'h00);
    rst_n = 1'b1;
    cyc();

    // Full load of bank 3 with 1,0,1,0... : first bit ends at chain end, entries become AA.
    serial(3'd3, 176, 0, done_at, pulses);
    check("load3_done_cycle", done_at, 175);
    check("load3_pulses", pulses, 1);
    check("load3_state_done", 32'(dbg_state), 32'(DONE));
    cyc();
    check("load3_pulse_cleared", load_done, 1'b0);
    check("load3_state_idle", 32'(dbg_state), 32'(IDLE));
    saddr = 3'd3; #1;
    check("sout_bank3", sout, 1'b1);
    saddr = 3'd2; #1;
    check("sout_bank2", sout, 1'b0);

    for (int i = 0; i < 15; i++) apply_vec(vecs[i], i);

    // Load of bank 1 in progress: writes to bank 1 dropped, bank 4 accepted, saddr change ignored.
    extra = 0;
    ssel = 1'b1; saddr = 3'd1;
    for (int i = 0; i < 12; i++) begin
      sin = 1'b1;
      if (i >= 5) saddr = 3'd6;
      if (i == 10) begin wr_en = 1'b1; wr_bank = 3'd1; wr_addr = 5'd0; wr_data = 8'h00; end
      if (i == 11) begin wr_en = 1'b1; wr_bank = 3'd4; wr_addr = 5'd3; wr_data = 8'h9C; end
      cyc();
      wr_en = 1'b0;
      if (load_done) extra++;
      if (i == 10) check("conflict_wr_err", wr_err, 1'b1);
      if (i == 11) check("other_bank_wr_err", wr_err, 1'b0);
    end
    ssel = 1'b0; sin = 1'b0;
    cyc();
    check("abort_state_idle", 32'(dbg_state), 32'(IDLE));
    check("abort_no_done", extra + int'(load_done), 0);
    do_read(3'd1, 5'd0, 8'hFF, 1'b0, "abort_b1a0");
    do_read(3'd1, 5'd1, 8'h0F, 1'b0, "abort_b1a1");
    do_read(3'd4, 5'd3, 8'h9C, 1'b0, "b4a3");
    do_read(3'd6, 5'd0, 8'h00, 1'b0, "b6a0_untouched");
    do_read(3'd3, 5'd5, 8'hAA, 1'b0, "b3a5_kept");

    // A full load after an abort must restart the bit count from zero.
    serial(3'd0, 176, 1, done_at, pulses);
    check("load0_done_cycle", done_at, 175);
    cyc();
    do_read(3'd0, 5'd21, 8'hFF, 1'b0, "b0a21");

    // Reset at shift cycle 100 of bank 3; original bit 75 (AA bit 3) is then at chain end.
    serial(3'd3, 100, 1, done_at, pulses);
    check("partial_no_done", pulses, 0);
    ssel = 1'b1; saddr = 3'd3; #1;
    check("partial_sout", sout, 1'b1);
    rst_n = 1'b0; #1;
    check("rst_state", 32'(dbg_state), 32'(IDLE));
    check("rst_sout", sout, 1'b0);
    check("rst_load_done", load_done, 1'b0);
    check("rst_rd_valid", rd_valid, 1'b0);
    check("rst_rd_err", rd_err, 1'b0);
    check("rst_rd_data", rd_data, 8'h00);
    ssel = 1'b0;
    repeat (2) cyc();
    rst_n = 1'b1;
    extra = 0;
    for (int i = 0; i < 200; i++) begin
      cyc();
      if (load_done) extra++;
    end
    check("post_rst_no_done", extra, 0);
    do_read(3'd3, 5'd0, 8'h00, 1'b0, "rst_b3a0");
    do_read(3'd5, 5'd21, 8'h00, 1'b0, "rst_b5a21");
    do_read(3'd0, 5'd21, 8'h00, 1'b0, "rst_b0a21");
    do_read(3'd1, 5'd0, 8'h00, 1'b0, "rst_b1a0");

    serial(3'd7, 176, 2, done_at, pulses);
    check("load7_done_cycle", done_at, 175);
    check("load7_pulses", pulses, 1);
    cyc();
    check("load7_pulse_cleared", load_done, 1'b0);
    do_write(3'd2, 5'd4, 8'h3C, 1'b0, "b2a4");

    // Back-to-back reads: results appear on consecutive cycles after LAT edges.
    begin
      logic [2:0] rb [4];
      logic [4:0] ra [4];
      logic [7:0] ed [4];
      logic       ee [4];
      rb = '{3'd7, 3'd2, 3'd7, 3'd2};
      ra = '{5'd0, 5'd4, 5'd1, 5'd30};
      ed = '{8'hFF, 8'h3C, 8'h00, 8'h00};
      ee = '{1'b0, 1'b0, 1'b0, 1'b1};
      for (int t = 0; t < 4 + LAT - 1; t++) begin
        if (t < 4) begin
          rd_en = 1'b1; rd_bank = rb[t]; rd_addr = ra[t];
        end else begin
          rd_en = 1'b0;
        end
        cyc();
        if (t - (LAT - 1) < 0) begin
          check("pipe_fill_valid", rd_valid, 1'b0);
        end else begin
          check($sformatf("pipe%0d_valid", t - LAT + 1), rd_valid, 1'b1);
          check($sformatf("pipe%0d_data", t - LAT + 1), rd_data, ed[t - LAT + 1]);
          check($sformatf("pipe%0d_err", t - LAT + 1), rd_err, ee[t - LAT + 1]);
        end
      end
      rd_en = 1'b0;
      cyc();
      check("pipe_drain_valid", rd_valid, 1'b0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
